abus_regfile: RTL and testbench

Register-bank slave on the abus slave port: responds to `abus_sreq` transfers from `abus_arbiter` with a configurable number of wait states. It owns `NB_REG` DATA_WIDTH-bit registers, applies bit-field (strb/keep) writes and reads, and honours aborts. It sits beside the sram slaves and exposes the register contents and per-register write strobes to hardware, which supplies the values of read-only registers.

---
 rtl/abus_regfile.sv | 226 ++++++++++++++++++++++
 tb/tb_abus_regfile.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/abus_regfile.sv
// abus_regfile: abus slave owning NB_REG bit-field addressable registers, with
// fixed wait states, abort during wait, and protection against held requests.
module abus_regfile #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 16'h0600,
  parameter int                    NB_REG      = 8,
  parameter int                    WAIT_STATE  = 1,
  parameter logic [NB_REG-1:0]     RO_MASK     = 8'h80,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    SK_SIZE     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                         abus_clk,
  input  logic                         abus_rst,
  input  logic                         abus_sreq,
  input  logic                         abus_swrite,
  input  logic                         abus_sread,
  input  logic                         abus_sabort,
  input  logic [ADDR_WIDTH-1:0]        abus_saddress,
  input  logic [DATA_WIDTH-1:0]        abus_swdata,
  input  logic [SK_SIZE-1:0]           abus_sstrb,
  input  logic [SK_SIZE-1:0]           abus_skeep,
  input  logic [2:0]                   abus_smid,
  output logic                         abus_sack,
  output logic [DATA_WIDTH-1:0]        abus_srdata,
  output logic [NB_REG*DATA_WIDTH-1:0] reg_q,
  output logic [NB_REG-1:0]            reg_wr,
  input  logic [NB_REG*DATA_WIDTH-1:0] hw_status
);

  localparam int OFF_W = (NB_REG > 1) ? $clog2(NB_REG) : 1;
  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, START_ADDR} + (ADDR_WIDTH + 1)'(NB_REG);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  wr_op_q, wr_op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SK_SIZE-1:0]    strb_q, strb_d;
  logic [SK_SIZE-1:0]    keep_q, keep_d;
  logic [2:0]            mid_q, mid_d;
  logic                  sack_q, sack_d;
  logic [DATA_WIDTH-1:0] srdata_q, srdata_d;
  logic [NB_REG-1:0]     reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] regs_q [NB_REG];
  logic [DATA_WIDTH-1:0] regs_d [NB_REG];
  logic [DATA_WIDTH-1:0] slot_val [NB_REG];

  logic                  in_range;
  logic                  req_ok;
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [OFF_W-1:0]      off_in;
  logic                  enter_ack;
  logic [OFF_W-1:0]      cur_off;
  logic                  cur_wr;
  logic [SK_SIZE-1:0]    cur_strb;
  logic [SK_SIZE-1:0]    cur_keep;

  // Mask of the low `keep` bits; one spare bit keeps keep==DATA_WIDTH exact.
  function automatic logic [DATA_WIDTH:0] field_mask(input logic [SK_SIZE-1:0] keep);
    logic [DATA_WIDTH:0] top;
    if (int'(keep) >= DATA_WIDTH) top = {1'b1, {DATA_WIDTH{1'b0}}};
    else                          top = (DATA_WIDTH + 1)'(1) << keep;
    return top - (DATA_WIDTH + 1)'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] field_read(
    input logic [DATA_WIDTH-1:0] src,
    input logic [SK_SIZE-1:0]    strb,
    input logic [SK_SIZE-1:0]    keep
  );
    logic [DATA_WIDTH:0] shifted;
    shifted = ({1'b0, src} >> strb) & field_mask(keep);
    return shifted[DATA_WIDTH-1:0];
  endfunction

  // Bits shifted past DATA_WIDTH-1 fall off the truncation and are dropped.
  function automatic logic [DATA_WIDTH-1:0] field_merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [SK_SIZE-1:0]    strb,
    input logic [SK_SIZE-1:0]    keep
  );
    logic [DATA_WIDTH:0] mask;
    logic [DATA_WIDTH:0] data;
    mask = field_mask(keep);
    data = ({1'b0, wdata} & mask) << strb;
    mask = mask << strb;
    return (old & ~mask[DATA_WIDTH-1:0]) | data[DATA_WIDTH-1:0];
  endfunction

  for (genvar i = 0; i < NB_REG; i++) begin : g_slot
    assign slot_val[i] = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = slot_val[i];
  end

  assign in_range = ({1'b0, abus_saddress} >= {1'b0, START_ADDR}) &&
                    ({1'b0, abus_saddress} <  END_ADDR);
  assign req_ok   = abus_sreq && in_range && (abus_sread || abus_swrite);
  assign addr_off = abus_saddress - START_ADDR;
  assign off_in   = addr_off[OFF_W-1:0];

  // With zero wait states the ack is issued straight from IDLE, before the
  // request fields have been latched, so the read path takes them live.
  assign cur_off  = (state_q == S_IDLE) ? off_in      : off_q;
  assign cur_wr   = (state_q == S_IDLE) ? abus_swrite : wr_op_q;
  assign cur_strb = (state_q == S_IDLE) ? abus_sstrb  : strb_q;
  assign cur_keep = (state_q == S_IDLE) ? abus_skeep  : keep_q;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    wr_op_d   = wr_op_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    keep_d    = keep_q;
    mid_d     = mid_q;
    sack_d    = 1'b0;
    srdata_d  = '0;
    reg_wr_d  = '0;
    regs_d    = regs_q;
    enter_ack = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          off_d   = off_in;
          wr_op_d = abus_swrite;
          wdata_d = abus_swdata;
          strb_d  = abus_sstrb;
          keep_d  = abus_skeep;
          mid_d   = abus_smid;
          if (WAIT_STATE > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATE);
          end else begin
            enter_ack = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (abus_sabort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d     = '0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_DONE;
        if (wr_op_q && !RO_MASK[off_q] && (keep_q != '0)) begin
          regs_d[off_q]   = field_merge(regs_q[off_q], wdata_q, strb_q, keep_q);
          reg_wr_d[off_q] = 1'b1;
        end
      end
      S_DONE: begin
        if (!abus_sreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_ack) begin
      state_d = S_ACK;
      sack_d  = 1'b1;
      if (!cur_wr) srdata_d = field_read(slot_val[cur_off], cur_strb, cur_keep);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sack_q   <= 1'b0;
      srdata_q <= '0;
      reg_wr_q <= '0;
      // NOTE: the bank is a handful of flops whose contents are architecturally
      // defined after reset, so it is reset explicitly rather than left as RAM.
      for (int i = 0; i < NB_REG; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sack_q   <= sack_d;
      srdata_q <= srdata_d;
      reg_wr_q <= reg_wr_d;
      regs_q   <= regs_d;
    end
  end

  // Request fields are only consumed after being loaded in IDLE; no reset needed.
  always_ff @(posedge abus_clk) begin
    off_q   <= off_d;
    wr_op_q <= wr_op_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
    keep_q  <= keep_d;
    mid_q   <= mid_d;
  end

  assign abus_sack   = sack_q;
  assign abus_srdata = srdata_q;
  assign reg_wr      = reg_wr_q;

  a_sack_pulse: assert property (@(posedge abus_clk) disable iff (abus_rst)
    sack_q |=> !sack_q);
  a_wr_onehot: assert property (@(posedge abus_clk) disable iff (abus_rst)
    $onehot0(reg_wr_q));
  a_rdata_quiet: assert property (@(posedge abus_clk) disable iff (abus_rst)
    !sack_q |-> (srdata_q == '0));

endmodule

// File: tb/tb_abus_regfile.sv
// Randomised bench for abus_regfile: two instances (1 and 3 wait states)
// checked against a bit-level array model of the register bank.
module tb_abus_regfile;

  localparam logic [15:0] BASE = 16'h0600;
  localparam logic [7:0]  RO   = 8'h80;
  localparam logic [15:0] RV1  = 16'h1357;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst    [2];
  logic         sreq   [2];
  logic         swrite [2];
  logic         sread  [2];
  logic         sabort [2];
  logic [15:0]  saddr  [2];
  logic [15:0]  swdata [2];
  logic [4:0]   strb   [2];
  logic [4:0]   keep   [2];
  logic [2:0]   smid   [2];
  logic         sack   [2];
  logic [15:0]  srdata [2];
  logic [127:0] regq   [2];
  logic [7:0]   regwr  [2];
  logic [127:0] hw     [2];

  abus_regfile u_dut0 (
    .abus_clk(clk), .abus_rst(rst[0]), .abus_sreq(sreq[0]), .abus_swrite(swrite[0]),
    .abus_sread(sread[0]), .abus_sabort(sabort[0]), .abus_saddress(saddr[0]),
    .abus_swdata(swdata[0]), .abus_sstrb(strb[0]), .abus_skeep(keep[0]),
    .abus_smid(smid[0]), .abus_sack(sack[0]), .abus_srdata(srdata[0]),
    .reg_q(regq[0]), .reg_wr(regwr[0]), .hw_status(hw[0])
  );

  abus_regfile #(.WAIT_STATE(3), .RESET_VALUE(RV1)) u_dut1 (
    .abus_clk(clk), .abus_rst(rst[1]), .abus_sreq(sreq[1]), .abus_swrite(swrite[1]),
    .abus_sread(sread[1]), .abus_sabort(sabort[1]), .abus_saddress(saddr[1]),
    .abus_swdata(swdata[1]), .abus_sstrb(strb[1]), .abus_skeep(keep[1]),
    .abus_smid(smid[1]), .abus_sack(sack[1]), .abus_srdata(srdata[1]),
    .reg_q(regq[1]), .reg_wr(regwr[1]), .hw_status(hw[1])
  );

  logic [15:0] mdl [2][8];
  int ack_tot [2];
  int wr_tot  [2][8];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sack[k]) ack_tot[k]++;
      for (int i = 0; i < 8; i++) if (regwr[k][i]) wr_tot[k][i]++;
    end
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int wr_sum(input int k);
    int s = 0;
    for (int i = 0; i < 8; i++) s += wr_tot[k][i];
    return s;
  endfunction

  function automatic logic [15:0] slot_exp(input int k, input int i);
    if (RO[i]) return hw[k][i*16 +: 16];
    return mdl[k][i];
  endfunction

  function automatic logic [15:0] fld_read(input logic [15:0] src, input int s, input int kp);
    logic [15:0] r = '0;
    for (int b = 0; b < 16; b++) if (b < kp && b + s < 16) r[b] = src[b + s];
    return r;
  endfunction

  task automatic model_write(input int k, input int i, input logic [15:0] wd,
                             input int s, input int kp);
    if (RO[i]) return;
    for (int b = 0; b < 16; b++) if (b >= s && b < s + kp) mdl[k][i][b] = wd[b - s];
  endtask

  task automatic check_slots(input int k, input string tag);
    for (int i = 0; i < 8; i++) check(tag, regq[k][i*16 +: 16], slot_exp(k, i));
  endtask

  task automatic xfer(input int k, input logic [15:0] addr, input logic wr, input logic rd,
                      input logic [15:0] wd, input int s, input int kp, input int hold,
                      output logic [15:0] got_rd);
    int off, lat, a0, w0, wa0;
    bit valid;
    logic [15:0] exp_rd;
    off   = int'(addr) - int'(BASE);
    valid = (off >= 0) && (off < 8) && (wr || rd);
    if (off < 0 || off > 7) off = 0;
    exp_rd = fld_read(slot_exp(k, off), s, kp);
    a0 = ack_tot[k]; w0 = wr_tot[k][off]; wa0 = wr_sum(k);
    got_rd = '0; lat = 0;
    @(negedge clk);
    sreq[k] = 1'b1; saddr[k] = addr; swrite[k] = wr; sread[k] = rd; swdata[k] = wd;
    strb[k] = 5'(s); keep[k] = 5'(kp); smid[k] = 3'($urandom_range(0, 7));
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (sack[k]) begin lat = c; got_rd = srdata[k]; break; end
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    sreq[k] = 1'b0; swrite[k] = 1'b0; sread[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (valid && wr) model_write(k, off, wd, s, kp);
    if (valid) begin
      check("ack_latency", lat, ws_of(k) + 1);
      if (!wr) check("read_data", got_rd, exp_rd);
      check("ack_count", ack_tot[k] - a0, 1);
      if (!wr || RO[off]) check("no_reg_wr", wr_sum(k) - wa0, 0);
      else if (kp != 0 && s < 16) begin
        check("reg_wr_pulse", wr_tot[k][off] - w0, 1);
        check("reg_wr_total", wr_sum(k) - wa0, 1);
      end
      check("slot_value", regq[k][off*16 +: 16], slot_exp(k, off));
    end else begin
      check("ignored_no_ack", ack_tot[k] - a0, 0);
      check("ignored_no_wr", wr_sum(k) - wa0, 0);
    end
    check("srdata_idle", srdata[k], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, wa0, k, r;
    logic [15:0] rd, addr;
    for (int j = 0; j < 2; j++) begin
      rst[j] = 1'b1; sreq[j] = 1'b0; swrite[j] = 1'b0; sread[j] = 1'b0; sabort[j] = 1'b0;
      saddr[j] = '0; swdata[j] = '0; strb[j] = '0; keep[j] = '0; smid[j] = '0;
      hw[j] = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin mdl[0][i] = 16'h0000; mdl[1][i] = RV1; end
    #1;
    for (int j = 0; j < 2; j++) begin
      check("rst_sack", sack[j], 0);
      check("rst_srdata", srdata[j], 0);
      check("rst_reg_wr", regwr[j], 0);
      check_slots(j, "rst_slot");
    end

    xfer(0, BASE, 1, 0, 16'hCAFE, 0, 16, 0, rd);
    check("cafe_value", regq[0][15:0], 16'hCAFE);

    xfer(0, BASE + 16'd1, 1, 0, 16'hFFFF, 0, 16, 0, rd);
    xfer(0, BASE + 16'd1, 1, 0, 16'h0000, 4, 4, 0, rd);
    check("field_write", regq[0][31:16], 16'hFF0F);
    xfer(0, BASE + 16'd1, 0, 1, 16'h0000, 8, 8, 0, rd);
    check("field_read", rd, 16'h00FF);

    hw[0][127:112] = 16'h55AA;
    xfer(0, BASE + 16'd7, 1, 0, 16'h1234, 0, 16, 0, rd);
    xfer(0, BASE + 16'd7, 0, 1, 16'h0000, 0, 16, 0, rd);
    check("ro_read", rd, 16'h55AA);

    xfer(0, BASE + 16'd8, 1, 0, 16'hDEAD, 0, 16, 0, rd);
    check_slots(0, "oor_slot");

    xfer(0, BASE + 16'd3, 1, 0, 16'hA5C3, 0, 16, 6, rd);

    a0 = ack_tot[1]; wa0 = wr_sum(1);
    @(negedge clk);
    sreq[1] = 1'b1; saddr[1] = BASE + 16'd2; swrite[1] = 1'b1; sread[1] = 1'b0;
    swdata[1] = 16'hBEEF; strb[1] = 5'd0; keep[1] = 5'd16;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    sabort[1] = 1'b1; sreq[1] = 1'b0; swrite[1] = 1'b0;
    @(negedge clk);
    sabort[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_ack", ack_tot[1] - a0, 0);
    check("abort_no_wr", wr_sum(1) - wa0, 0);
    check("abort_slot", regq[1][47:32], mdl[1][2]);
    xfer(1, BASE + 16'd2, 1, 0, 16'h4321, 0, 16, 0, rd);

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) hw[k] = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 15) == 0) addr = ($urandom_range(0, 1) == 0) ? BASE + 16'd8 : BASE - 16'd1;
      else addr = BASE + 16'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      xfer(k, addr, (r < 4) || (r == 8), (r >= 4) && (r != 9), 16'($urandom),
           int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
           int'($urandom_range(0, 2)), rd);
    end

    xfer(1, BASE + 16'd3, 1, 0, 16'h7777, 0, 16, 0, rd);
    a0 = ack_tot[1]; wa0 = wr_sum(1);
    @(negedge clk);
    sreq[1] = 1'b1; saddr[1] = BASE + 16'd3; swrite[1] = 1'b1; sread[1] = 1'b0;
    swdata[1] = 16'h0F0F; strb[1] = 5'd0; keep[1] = 5'd16;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1; sreq[1] = 1'b0; swrite[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 8; i++) mdl[1][i] = RV1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_wait_no_ack", ack_tot[1] - a0, 0);
    check("rst_wait_no_wr", wr_sum(1) - wa0, 0);
    check("rst_wait_sack", sack[1], 0);
    check_slots(1, "rst_wait_slot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
